// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding and default geometry for the ccff chain driver.
package fpga_cfg_pkg;
    localparam int CHAIN_LEN_DEF = 4;
    localparam int WORD_W_DEF = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_RB_SHIFT,
        ST_RB_OUT,
        ST_DONE
    } state_e;
endpackage

// File: rtl/ccff_chain_driver_if.sv
// ccff_chain_driver_if: bitstream write and readback valid/ready streams.
interface ccff_chain_driver_if import fpga_cfg_pkg::*; #(
    parameter int WORD_W = WORD_W_DEF
) ();
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    modport master (output wr_data, wr_valid, rd_ready, input wr_ready, rd_data, rd_valid);
    modport slave (input wr_data, wr_valid, rd_ready, output wr_ready, rd_data, rd_valid);
endinterface

// File: rtl/ccff_chain_driver_shift_unit.sv
// ccff_shift_unit: word register with parallel load, MSB-first serial out and indexed serial capture.
module ccff_shift_unit import fpga_cfg_pkg::*; #(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [WORD_W-1:0]         load_data_i,
    input  logic                      shift_i,
    input  logic                      sample_i,
    input  logic                      sin_i,
    input  logic [$clog2(WORD_W)-1:0] idx_i,
    output logic                      sout_o,
    output logic [WORD_W-1:0]         data_o
);
    localparam int IW = $clog2(WORD_W);
    logic [WORD_W-1:0] sr_q, sr_d, ins;
    // captured bits fill from the MSB down so a partial word keeps zeroed LSBs
    always_comb begin
        ins = sr_q;
        ins[IW'(WORD_W - 1) - idx_i] = sin_i;
        sr_d = clear_i ? '0 :
               load_i ? load_data_i :
               shift_i ? {sr_q[WORD_W-2:0], 1'b0} :
               sample_i ? ins : sr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else sr_q <= sr_d;
    end
    assign sout_o = sr_q[WORD_W-1];
    assign data_o = sr_q;
endmodule

// File: rtl/ccff_chain_driver.sv
// ccff_chain_driver: programs a configuration flip-flop chain from a word stream and reads it back
// by recirculating the chain through its own head.
module ccff_chain_driver import fpga_cfg_pkg::*; #(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                      prog_clk,
    input  logic                      pReset,
    input  logic                      start,
    input  logic                      readback_req,
    ccff_chain_driver_if.slave        bus,
    output logic                      ccff_head,
    input  logic                      ccff_tail,
    output logic                      config_enable,
    output logic                      config_readback,
    output logic                      busy,
    output logic                      done
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(WORD_W);
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic              shift_en, cnt_last, word_last, rd_hs, sout;
    logic [WORD_W-1:0] word;
    always_comb begin
        shift_en = state_q == ST_SHIFT || state_q == ST_RB_SHIFT;
        cnt_last = cnt_q == CW'(CHAIN_LEN - 1);
        word_last = bit_q == IW'(WORD_W - 1);
        rd_hs = state_q == ST_RB_OUT && bus.rd_ready;
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = start ? ST_LOAD : readback_req ? ST_RB_SHIFT : ST_IDLE;
            ST_LOAD:     state_d = bus.wr_valid ? ST_SHIFT : ST_LOAD;
            ST_SHIFT:    state_d = cnt_last ? ST_DONE : word_last ? ST_LOAD : ST_SHIFT;
            ST_RB_SHIFT: state_d = cnt_last || word_last ? ST_RB_OUT : ST_RB_SHIFT;
            ST_RB_OUT:   state_d = !bus.rd_ready ? ST_RB_OUT : cnt_q == CW'(CHAIN_LEN) ? ST_DONE : ST_RB_SHIFT;
            default:     state_d = ST_IDLE;
        endcase
        cnt_d = state_q == ST_IDLE ? '0 : cnt_q + CW'(shift_en);
        bit_d = shift_en && !word_last ? bit_q + 1'b1 : '0;
    end
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end
    ccff_shift_unit #(.WORD_W(WORD_W)) u_shift (
        .clk         (prog_clk),
        .rst         (pReset),
        .clear_i     (state_q == ST_IDLE || rd_hs),
        .load_i      (state_q == ST_LOAD && bus.wr_valid),
        .load_data_i (bus.wr_data),
        .shift_i     (state_q == ST_SHIFT),
        .sample_i    (state_q == ST_RB_SHIFT),
        .sin_i       (ccff_tail),
        .idx_i       (bit_q),
        .sout_o      (sout),
        .data_o      (word)
    );
    assign ccff_head = state_q == ST_SHIFT ? sout : state_q == ST_RB_SHIFT ? ccff_tail : 1'b0;
    assign config_enable = shift_en;
    assign config_readback = state_q == ST_RB_SHIFT || state_q == ST_RB_OUT;
    assign bus.wr_ready = state_q == ST_LOAD;
    assign bus.rd_valid = state_q == ST_RB_OUT;
    assign bus.rd_data = bus.rd_valid ? word : '0;
    assign busy = state_q != ST_IDLE;
    assign done = state_q == ST_DONE;
endmodule

// File: tb/tb_ccff_chain_driver.sv
// tb_ccff_chain_driver: table-driven program/readback vectors against a 12-FF chain model, plus corner sequences.
module tb_ccff_chain_driver;
    localparam int CL = 12;
    localparam int WW = 8;
    logic prog_clk = 1'b0, pReset = 1'b1, start = 1'b0, readback_req = 1'b0;
    logic ccff_head, ccff_tail, config_enable, config_readback, busy, done;
    logic [CL-1:0] chain = '0;
    ccff_chain_driver_if #(.WORD_W(WW)) bus ();
    ccff_chain_driver #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .start           (start),
        .readback_req    (readback_req),
        .bus             (bus),
        .ccff_head       (ccff_head),
        .ccff_tail       (ccff_tail),
        .config_enable   (config_enable),
        .config_readback (config_readback),
        .busy            (busy),
        .done            (done)
    );
    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) if (config_enable) chain <= {chain[CL-2:0], ccff_head};
    assign ccff_tail = chain[CL-1];
    typedef struct {
        logic s, r, wv;
        logic [7:0] wd;
        logic rr;
        logic [6:0] f;
        logic [7:0] d;
    } vec_t;
    // flag order: head, enable, readback, wr_ready, rd_valid, busy, done
    localparam logic [6:0] F_IDLE = 7'b0000000;
    localparam logic [6:0] F_LOAD = 7'b0001010;
    localparam logic [6:0] F_RBO  = 7'b0010110;
    localparam logic [6:0] F_DONE = 7'b0000011;
    vec_t vecs[$];
    int applied = 0, miscompares = 0;
    function automatic vec_t mk(logic s, logic r, logic wv, logic [7:0] wd, logic rr, logic [6:0] f, logic [7:0] d);
        vec_t v;
        v.s = s; v.r = r; v.wv = wv; v.wd = wd; v.rr = rr; v.f = f; v.d = d;
        return v;
    endfunction
    function automatic logic [6:0] flags();
        return {ccff_head, config_enable, config_readback, bus.wr_ready, bus.rd_valid, busy, done};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    initial begin
        logic [CL-1:0] stream, got;
        logic dseen, bseen;
        int nb;
        stream = 12'hA53;
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, F_IDLE, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'hA5, 0, F_LOAD, 8'h00));
        for (int k = 0; k < 8; k++) vecs.push_back(mk(k == 3, k == 3, 0, 8'h00, 0, {stream[11-k], 6'b100010}, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h3C, 0, F_LOAD, 8'h00));
        for (int k = 8; k < 12; k++) vecs.push_back(mk(0, 0, 0, 8'h00, 0, {stream[11-k], 6'b100010}, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, F_DONE, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, F_IDLE, 8'h00));
        for (int p = 0; p < 2; p++) begin
            vecs.push_back(mk(0, 1, 0, 8'h00, 0, F_IDLE, 8'h00));
            for (int k = 0; k < 8; k++) vecs.push_back(mk(0, 0, 0, 8'h00, 0, {stream[11-k], 6'b110010}, 8'h00));
            vecs.push_back(mk(p == 0, 0, 0, 8'h00, 1, F_RBO, 8'hA5));
            for (int k = 8; k < 12; k++) vecs.push_back(mk(0, 0, 0, 8'h00, 0, {stream[11-k], 6'b110010}, 8'h00));
            vecs.push_back(mk(0, 0, 0, 8'h00, 1, F_RBO, 8'h30));
            vecs.push_back(mk(0, 0, 0, 8'h00, 0, F_DONE, 8'h00));
            vecs.push_back(mk(0, 0, 0, 8'h00, 0, F_IDLE, 8'h00));
        end
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        repeat (3) @(negedge prog_clk);
        chk("reset_state", {25'd0, flags()}, 32'd0);
        chk("reset_rd_data", {24'd0, bus.rd_data}, 32'd0);
        pReset = 1'b0;
        foreach (vecs[i]) begin
            start = vecs[i].s; readback_req = vecs[i].r;
            bus.wr_valid = vecs[i].wv; bus.wr_data = vecs[i].wd; bus.rd_ready = vecs[i].rr;
            #1;
            chk($sformatf("vec%0d", i), {17'd0, flags(), vecs[i].f[2] ? bus.rd_data : 8'h00}, {17'd0, vecs[i].f, vecs[i].d});
            @(negedge prog_clk);
        end
        start = 1'b0; readback_req = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        // write 0x5A, 0xC3 with three idle LOAD cycles before each word
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        got = '0; nb = 0;
        for (int w = 0; w < 2; w++) begin
            for (int g = 0; g < 3; g++) begin
                chk("gap_load", {29'd0, config_enable, bus.wr_ready, ccff_head}, 32'b010);
                @(negedge prog_clk);
            end
            bus.wr_valid = 1'b1; bus.wr_data = w == 0 ? 8'h5A : 8'hC3;
            @(negedge prog_clk);
            bus.wr_valid = 1'b0;
            for (int k = 0; k < 8 && config_enable; k++) begin
                got = {got[CL-2:0], ccff_head}; nb++;
                @(negedge prog_clk);
            end
        end
        chk("gap_bit_count", nb, 12);
        chk("gap_stream", {20'd0, got}, 32'h5AC);
        chk("gap_done", {30'd0, done, busy}, 32'b11);
        @(negedge prog_clk);
        chk("gap_after_done", {30'd0, done, busy}, 32'b00);
        chk("gap_chain", {20'd0, chain}, 32'h5AC);
        // readback with the consumer stalled for five cycles on the first word
        readback_req = 1'b1;
        @(negedge prog_clk);
        readback_req = 1'b0;
        chk("rb_mode", {29'd0, config_readback, config_enable, busy}, 32'b111);
        for (int k = 0; k < 20 && !bus.rd_valid; k++) @(negedge prog_clk);
        chk("rb_first_valid", {31'd0, bus.rd_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("rb_stall", {22'd0, bus.rd_valid, config_enable, bus.rd_data}, {22'd0, 2'b10, 8'h5A});
            @(negedge prog_clk);
        end
        bus.rd_ready = 1'b1;
        @(negedge prog_clk);
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 20 && !bus.rd_valid; k++) @(negedge prog_clk);
        chk("rb_second", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'hC0});
        bus.rd_ready = 1'b1;
        @(negedge prog_clk);
        bus.rd_ready = 1'b0;
        chk("rb_done", {31'd0, done}, 32'd1);
        @(negedge prog_clk);
        chk("rb_chain_kept", {20'd0, chain}, 32'h5AC);
        // reset five bits into a shift
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 8'hFF;
        @(negedge prog_clk);
        bus.wr_valid = 1'b0;
        repeat (5) @(negedge prog_clk);
        chk("abort_mid_shift", {30'd0, config_enable, busy}, 32'b11);
        pReset = 1'b1;
        dseen = done;
        @(negedge prog_clk);
        chk("abort_idle", {28'd0, busy, config_enable, ccff_head, done}, 32'd0);
        pReset = 1'b0;
        bseen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge prog_clk);
            dseen |= done;
            bseen |= busy;
        end
        chk("abort_no_done", {30'd0, dseen, bseen}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/ccff_chain_driver.md
CCFF_CHAIN_DRIVER -- requirements
Module: ccff_chain_driver

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 4, giving the number of configuration flip-flops in the downstream ccff chain.
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width on both the write and read ports.
REQ-003 SHALL have port prog_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port pReset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: program request, sampled in IDLE only.
REQ-006 SHALL have port readback_req, input, 1 bit: readback request, sampled in IDLE only.
REQ-007 SHALL have ports wr_data (input, WORD_W), wr_valid (input, 1) and wr_ready (output, 1): bitstream word in, valid/ready handshake.
REQ-008 SHALL have ports rd_data (output, WORD_W), rd_valid (output, 1) and rd_ready (input, 1): readback word out, valid/ready handshake.
REQ-009 SHALL have port ccff_head, output, 1 bit: serial data into the chain head.
REQ-010 SHALL have port ccff_tail, input, 1 bit: serial data from the chain tail.
REQ-011 SHALL have port config_enable, output, 1 bit: the chain shifts one position on each prog_clk edge while it is high.
REQ-012 SHALL have port config_readback, output, 1 bit: high while in readback mode.
REQ-013 SHALL have ports busy (output, 1: high whenever state is not IDLE) and done (output, 1: single-cycle completion pulse).

Function
REQ-014 SHALL implement states IDLE, LOAD, SHIFT, RB_SHIFT, RB_OUT, DONE.
REQ-015 In IDLE, start=1 SHALL go to LOAD and readback_req=1 SHALL go to RB_SHIFT; if both are high in the same cycle, start SHALL win.
REQ-016 In LOAD, wr_ready SHALL be 1; wr_ready SHALL be 0 in every other state.
REQ-017 In LOAD, a wr_valid&wr_ready handshake SHALL capture wr_data and go to SHIFT; with no handshake the block SHALL hold in LOAD with config_enable=0.
REQ-018 SHIFT SHALL drive ccff_head with the word bits MSB first, one bit per cycle, with config_enable=1 in every SHIFT cycle and 0 in every LOAD cycle.
REQ-019 SHALL keep a total-bit counter wide enough for CHAIN_LEN, cleared on entry from IDLE and incremented once per enabled shift.
REQ-020 When the counter reaches CHAIN_LEN, SHIFT SHALL go to DONE; the unused LSBs of the final partial word SHALL be discarded.
REQ-021 When all WORD_W bits of a word are shifted and the counter is below CHAIN_LEN, SHIFT SHALL go to LOAD.
REQ-022 In RB_SHIFT, config_readback=1, config_enable=1 and ccff_head=ccff_tail, so the chain recirculates and is unchanged after CHAIN_LEN shifts.
REQ-023 RB_SHIFT SHALL sample ccff_tail before each shift edge, placing the first bit of each word at bit WORD_W-1, so the read stream equals the written stream in order.
REQ-024 After WORD_W samples, or at counter==CHAIN_LEN, RB_SHIFT SHALL go to RB_OUT; a final partial word SHALL have its unfilled LSBs set to 0.
REQ-025 In RB_OUT, rd_valid SHALL be 1 and rd_data SHALL be stable with config_enable=0 until rd_ready; on handshake, go to RB_SHIFT, or to DONE if the counter equals CHAIN_LEN.
REQ-026 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-027 start and readback_req outside IDLE SHALL be ignored and not queued.
REQ-028 Outside SHIFT and RB_SHIFT, ccff_head SHALL be 0.

Reset
REQ-029 When pReset=1, the block SHALL enter IDLE with counter=0, config_enable=0, config_readback=0, ccff_head=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0.
REQ-030 Reset mid-operation SHALL abort within one cycle; chain contents are then undefined, and no done pulse SHALL be produced.

Structure
REQ-031 Package fpga_cfg_pkg SHALL hold the state enum type and the default CHAIN_LEN and WORD_W constants.
REQ-032 SHALL contain one sub-module, ccff_shift_unit, holding the WORD_W shift register with parallel-load, serial-out and serial-in/parallel-out modes; the FSM and counter stay in the top level.

Verification
REQ-033 CHAIN_LEN=12, WORD_W=8, start, write 0xA5 then 0x3C -> ccff_head=1,0,1,0,0,1,0,1,0,0,1,1 over 12 enable cycles, then one done pulse.
REQ-034 Same chain model, readback_req after REQ-033 -> rd_data 0xA5 then 0x30; a second readback -> identical words (recirculation intact).
REQ-035 wr_valid held low 3 cycles between words -> config_enable=0 for those 3 cycles, no bits lost or duplicated.
REQ-036 rd_ready held low 5 cycles in RB_OUT -> rd_valid=1 and rd_data stable throughout, config_enable=0.
REQ-037 start and readback_req asserted in the same IDLE cycle -> LOAD entered, config_readback stays 0.
REQ-038 pReset asserted after 5 SHIFT bits -> next cycle IDLE, config_enable=0, busy=0, done never pulses.
